// File: rtl/pipe_stage_reg.sv
// Generic pipeline-boundary register: STAGES cascaded slots of {valid, ctrl, data} with
// stall hold, flush-to-bubble and saturating stall/flush event counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pipe_stage_reg: STAGES must be in the range 1..4");
  end

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              v_q [STAGES];
  logic              v_d [STAGES];
  logic [CTRL_W-1:0] c_q [STAGES];
  logic [CTRL_W-1:0] c_d [STAGES];
  logic [DATA_W-1:0] d_q [STAGES];
  logic [DATA_W-1:0] d_d [STAGES];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Priority: reset > flush > stall > advance. Data is left untouched on flush.
  always_comb begin
    v_d         = v_q;
    c_d         = c_q;
    d_d         = d_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        v_d[k] = 1'b0;
        c_d[k] = '0;
        d_d[k] = '0;
      end
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (flush_i) begin
      for (int k = 0; k < STAGES; k++) begin
        v_d[k] = 1'b0;
        c_d[k] = '0;
      end
      if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall_i) begin
      if (stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      v_d[0] = valid_i;
      c_d[0] = valid_i ? ctrl_i : '0;
      d_d[0] = data_i;
      for (int k = 1; k < STAGES; k++) begin
        v_d[k] = v_q[k-1];
        c_d[k] = c_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    v_q         <= v_d;
    c_q         <= c_d;
    d_q         <= d_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign valid_o     = v_q[STAGES-1];
  assign ctrl_o      = c_q[STAGES-1];
  assign data_o      = d_q[STAGES-1];
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
